// File: rtl/eth_pkg.sv
// Shared types and constants for the MII receive capture path.
package eth_pkg;

  typedef enum logic [2:0] {
    GAP      = 3'd0,
    IDLE     = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    DROP     = 3'd4,
    FLUSH    = 3'd5
  } state_t;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  // Bit positions inside frame_err.
  localparam int ERR_RX    = 0;
  localparam int ERR_TRUNC = 1;

endpackage

// File: rtl/mii_sampler.sv
// Brings the raw MII receive pins into the mainclk domain and produces a
// one-cycle sample strobe on each rising edge of the synchronized rx clock.
module mii_sampler (
  input  logic       mainclk,
  input  logic       rst,
  input  logic       eth_rx_clk,
  input  logic       eth_rx_dv,
  input  logic [3:0] eth_rxd,
  input  logic       eth_rxerr,
  output logic       smp,
  output logic       dv,
  output logic [3:0] rxd,
  output logic       err
);

  // clk_sync[1] is the synced clock, clk_sync[2] its delayed copy.
  logic [2:0] clk_sync;
  logic [1:0] dv_sync;
  logic [1:0] err_sync;
  logic [3:0] rxd_s1;
  logic [3:0] rxd_s2;

  always_ff @(posedge mainclk) begin
    if (rst) begin
      clk_sync <= '0;
      dv_sync  <= '0;
      err_sync <= '0;
      rxd_s1   <= '0;
      rxd_s2   <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], eth_rx_clk};
      dv_sync  <= {dv_sync[0], eth_rx_dv};
      err_sync <= {err_sync[0], eth_rxerr};
      rxd_s1   <= eth_rxd;
      rxd_s2   <= rxd_s1;
    end
  end

  assign smp = clk_sync[1] & ~clk_sync[2];
  assign dv  = dv_sync[1];
  assign err = err_sync[1];
  assign rxd = rxd_s2;

endmodule

// File: rtl/mii_rx_deframer.sv
// Strips preamble/SFD from the sampled MII stream, packs payload bytes into
// little-endian 32-bit words for the frame RAM and reports length/status.
module mii_rx_deframer
  import eth_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int MAX_BYTES   = 1518,
  parameter int MAX_PRE_NIB = 15
) (
  input  logic              mainclk,
  input  logic              rst,
  input  logic              en,
  input  logic              eth_rx_clk,
  input  logic              eth_rx_dv,
  input  logic [3:0]        eth_rxd,
  input  logic              eth_rxerr,
  output logic              wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [10:0]       frame_len,
  output logic [1:0]        frame_err,
  output state_t            dbg_state
);

  localparam int PRE_W = $clog2(MAX_PRE_NIB + 2);

  if (((MAX_BYTES + 3) / 4) > (1 << ADDR_W)) begin : g_addr_range
    $error("mii_rx_deframer: MAX_BYTES does not fit in the frame RAM address space");
  end

  logic       smp;
  logic       s_dv;
  logic       s_err;
  logic [3:0] s_rxd;

  mii_sampler u_sampler (
    .mainclk    (mainclk),
    .rst        (rst),
    .eth_rx_clk (eth_rx_clk),
    .eth_rx_dv  (eth_rx_dv),
    .eth_rxd    (eth_rxd),
    .eth_rxerr  (eth_rxerr),
    .smp        (smp),
    .dv         (s_dv),
    .rxd        (s_rxd),
    .err        (s_err)
  );

  state_t             state;
  logic [PRE_W-1:0]   pre_cnt;
  logic [10:0]        byte_cnt;
  logic               nib_phase;
  logic [3:0]         low_nib;
  logic [31:0]        word_buf;
  logic [1:0]         lane;

  assign lane      = byte_cnt[1:0];
  assign dbg_state = state;

  always_ff @(posedge mainclk) begin
    if (rst) begin
      state      <= GAP;
      pre_cnt    <= '0;
      byte_cnt   <= '0;
      nib_phase  <= 1'b0;
      low_nib    <= '0;
      word_buf   <= '0;
      wr_ena     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= '0;
    end else begin
      wr_ena     <= 1'b0;
      frame_done <= 1'b0;
      if (wr_ena) wr_addr <= wr_addr + 1'b1;

      case (state)
        GAP: begin
          if (smp && !s_dv) state <= IDLE;
        end

        IDLE: begin
          if (smp && s_dv) begin
            if (en) begin
              state   <= PREAMBLE;
              pre_cnt <= PRE_W'(1);
              busy    <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end

        PREAMBLE: begin
          if (smp) begin
            if (!s_dv) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (s_rxd == SFD_NIB) begin
              state     <= DATA;
              byte_cnt  <= '0;
              nib_phase <= 1'b0;
              word_buf  <= '0;
              wr_addr   <= '0;
              frame_len <= '0;
              frame_err <= '0;
            end else if (s_rxd == PRE_NIB && int'(pre_cnt) < MAX_PRE_NIB) begin
              pre_cnt <= pre_cnt + 1'b1;
            end else begin
              state <= GAP;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (smp) begin
            if (!s_dv) begin
              // A dangling half byte is dropped and flagged.
              if (nib_phase) frame_err[ERR_TRUNC] <= 1'b1;
              state <= FLUSH;
              busy  <= 1'b0;
            end else if (byte_cnt == 11'(MAX_BYTES)) begin
              frame_err[ERR_TRUNC] <= 1'b1;
              state                <= DROP;
            end else begin
              if (s_err) frame_err[ERR_RX] <= 1'b1;
              nib_phase <= ~nib_phase;
              if (!nib_phase) begin
                low_nib <= s_rxd;
              end else begin
                byte_cnt <= byte_cnt + 11'd1;
                if (lane == 2'd3) begin
                  wr_data  <= {s_rxd, low_nib, word_buf[23:0]};
                  wr_ena   <= 1'b1;
                  word_buf <= '0;
                end else begin
                  word_buf[{lane, 3'b000} +: 8] <= {s_rxd, low_nib};
                end
              end
            end
          end
        end

        DROP: begin
          if (smp && !s_dv) begin
            state <= FLUSH;
            busy  <= 1'b0;
          end
        end

        FLUSH: begin
          // word_buf upper lanes are already zero for a partial word.
          if (lane != 2'd0) begin
            wr_data <= word_buf;
            wr_ena  <= 1'b1;
          end
          frame_done <= 1'b1;
          frame_len  <= byte_cnt;
          state      <= IDLE;
        end

        default: begin
          state <= GAP;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
